// File: rtl/cart_mapper_pkg.sv
// Shared constants and types for the MSX cartridge bank mapper.
// Optional bank readback is enabled with CART_BANK_READBACK_EN.
package cart_mapper_pkg;

  localparam logic [2:0] MODE_NOMAP   = 3'd1;
  localparam logic [2:0] MODE_KONAMI  = 3'd3;
  localparam logic [2:0] MODE_SCC     = 3'd4;
  localparam logic [2:0] MODE_ASCII8  = 3'd5;
  localparam logic [2:0] MODE_ASCII16 = 3'd6;
  localparam logic [2:0] MODE_LINEAR  = 3'd7;

  localparam logic [15:0] WIN_LO = 16'h4000;
  localparam logic [15:0] WIN_HI = 16'hBFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } rd_state_t;

  // Undefined mode codes 0 and 2 fall back to the plain nomapper layout.
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return (m == 3'd0 || m == 3'd2) ? MODE_NOMAP : m;
  endfunction

endpackage

// File: rtl/cart_bank_regs.sv
// Bank register file: write decode, write-strobe edge detect and
// reload of the mode defaults whenever the mapper mode changes.
module cart_bank_regs
  import cart_mapper_pkg::*;
#(
  parameter int BANK_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            mode,
  input  logic [4:0]            addr_hi,
  input  logic [BANK_W-1:0]     wr_data,
  input  logic                  wr,
  input  logic                  cs,
  output logic                  wr_rise,
  output logic [4*BANK_W-1:0]   bank_vec
);

  logic [2:0] mode_n;
  logic [2:0] mode_reg;
  logic       mode_chg;
  logic       ascii_mode;
  logic       wr_cs;
  logic       wr_cs_reg;
  logic [3:0] sel;

  assign mode_n     = norm_mode(mode);
  assign mode_chg   = (mode_n != mode_reg);
  assign ascii_mode = (mode_n == MODE_ASCII8) || (mode_n == MODE_ASCII16);
  assign wr_cs      = wr & cs;
  assign wr_rise    = wr_cs & ~wr_cs_reg;

  // mode_reg resets to a code norm_mode never produces, so the defaults of
  // whatever mode is selected are loaded on the first cycle after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg  <= 3'd0;
      wr_cs_reg <= 1'b0;
    end else begin
      mode_reg  <= mode_n;
      wr_cs_reg <= wr_cs;
    end
  end

  always_comb begin
    sel = 4'b0000;
    case (mode_n)
      MODE_KONAMI: begin
        case (addr_hi[4:2])
          3'b011:  sel = 4'b0010;
          3'b100:  sel = 4'b0100;
          3'b101:  sel = 4'b1000;
          default: sel = 4'b0000;
        endcase
      end
      MODE_SCC: begin
        case (addr_hi)
          5'b01010: sel = 4'b0001;
          5'b01110: sel = 4'b0010;
          5'b10010: sel = 4'b0100;
          5'b10110: sel = 4'b1000;
          default:  sel = 4'b0000;
        endcase
      end
      MODE_ASCII8: begin
        case (addr_hi)
          5'b01100: sel = 4'b0001;
          5'b01101: sel = 4'b0010;
          5'b01110: sel = 4'b0100;
          5'b01111: sel = 4'b1000;
          default:  sel = 4'b0000;
        endcase
      end
      MODE_ASCII16: begin
        case (addr_hi)
          5'b01100: sel = 4'b0001;
          5'b01110: sel = 4'b0010;
          default:  sel = 4'b0000;
        endcase
      end
      default: sel = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [BANK_W-1:0] bank_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          bank_reg <= BANK_W'(gi);
        end else if (mode_chg) begin
          bank_reg <= ascii_mode ? '0 : BANK_W'(gi);
        end else if (wr_rise && sel[gi]) begin
          bank_reg <= wr_data;
        end
      end

      assign bank_vec[gi*BANK_W +: BANK_W] = bank_reg;
    end
  endgenerate

endmodule

// File: rtl/cart_mapper_gen.sv
// MSX slot cartridge mapper: address translation plus a wait-state read
// handshake with timeout. CART_BANK_READBACK_EN adds ASCII bank readback.
module cart_mapper_gen
  import cart_mapper_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int BANK_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk_en,
  input  logic [2:0]          mode,
  input  logic [ADDR_W-1:0]   rom_size,
  input  logic [15:0]         addr,
  input  logic [7:0]          d_from_cpu,
  input  logic                wr,
  input  logic                rd,
  input  logic                cs,
  output logic [7:0]          d_to_cpu,
  output logic                cpu_wait,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_req,
  input  logic                mem_ack,
  input  logic [7:0]          mem_data,
  output logic [4*BANK_W-1:0] bank_dbg
);

  localparam int RAW_T = (BANK_W + 14 > 16) ? BANK_W + 14 : 16;
  localparam int RAW_W = (ADDR_W > RAW_T) ? ADDR_W : RAW_T;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  rd_state_t state_reg, state_next;

  logic [2:0]          mode_n;
  logic [4*BANK_W-1:0] bank_vec;
  logic [BANK_W-1:0]   banks [4];
  logic                wr_rise;
  logic                rd_cs, rd_cs_reg, rd_rise;
  logic                start_read, in_win, tmo_hit;
  logic                rb_hit;
  logic [7:0]          rb_data;
  logic [1:0]          page8k;
  logic [RAW_W-1:0]    raw_addr;
  logic [ADDR_W-1:0]   xlat;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [7:0]          d_to_cpu_reg;
  logic [15:0]         tmo_cnt_reg;

  cart_bank_regs #(.BANK_W(BANK_W)) u_bank_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .addr_hi  (addr[15:11]),
    .wr_data  (d_from_cpu[BANK_W-1:0]),
    .wr       (wr),
    .cs       (cs),
    .wr_rise  (wr_rise),
    .bank_vec (bank_vec)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign banks[gi] = bank_vec[gi*BANK_W +: BANK_W];
    end
  endgenerate

  assign mode_n = norm_mode(mode);
  assign page8k = addr[14:13] ^ 2'b10;

  always_comb begin
    raw_addr = '0;
    case (mode_n)
      MODE_LINEAR:  raw_addr = RAW_W'(addr);
      MODE_NOMAP:   raw_addr = RAW_W'(addr - WIN_LO);
      MODE_ASCII16: raw_addr = RAW_W'({banks[{1'b0, addr[15]}], addr[13:0]});
      default:      raw_addr = RAW_W'({banks[page8k], addr[12:0]});
    endcase
  end

  // Oversized bank numbers wrap onto the image through the size mask.
  assign xlat   = raw_addr[ADDR_W-1:0] & (rom_size - ADDR_W'(1));
  assign in_win = (mode_n == MODE_LINEAR) || (addr >= WIN_LO && addr <= WIN_HI);

`ifdef CART_BANK_READBACK_EN
  assign rb_hit  = ((mode_n == MODE_ASCII8) || (mode_n == MODE_ASCII16)) &&
                   (addr[15:2] == 14'h1FFE);
  assign rb_data = 8'(banks[addr[1:0]]);
`else
  assign rb_hit  = 1'b0;
  assign rb_data = 8'hFF;
`endif

  // A write rising together with a read wins; that read is never started.
  assign rd_cs      = rd & cs;
  assign rd_rise    = rd_cs & ~rd_cs_reg;
  assign start_read = (state_reg == ST_IDLE) && rd_rise && !wr_rise;
  assign tmo_hit    = clk_en && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_read) state_next = (in_win && !rb_hit) ? ST_REQ : ST_HOLD;
      ST_REQ:  if (mem_ack || tmo_hit) state_next = ST_HOLD;
      ST_HOLD: if (!rd_cs) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_req = 1'b0;
    cpu_wait   = 1'b0;
    if (state_reg == ST_REQ) begin
      mem_rd_req = 1'b1;
      cpu_wait   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cs_reg    <= 1'b0;
      d_to_cpu_reg <= 8'hFF;
      mem_addr_reg <= '0;
      tmo_cnt_reg  <= '0;
    end else begin
      rd_cs_reg <= rd_cs;
      if (start_read) begin
        if (rb_hit) begin
          d_to_cpu_reg <= rb_data;
        end else if (in_win) begin
          mem_addr_reg <= xlat;
          tmo_cnt_reg  <= '0;
        end else begin
          d_to_cpu_reg <= 8'hFF;
        end
      end else if (state_reg == ST_REQ) begin
        if (mem_ack)      d_to_cpu_reg <= mem_data;
        else if (tmo_hit) d_to_cpu_reg <= 8'hFF;
        else if (clk_en)  tmo_cnt_reg  <= tmo_cnt_reg + 16'd1;
      end
    end
  end

  assign d_to_cpu = d_to_cpu_reg;
  assign mem_addr = mem_addr_reg;
  assign bank_dbg = bank_vec;

endmodule

// File: doc/cart_mapper_gen.md
Name: cart_mapper_gen

Overview:
Parametrised cartridge bank mapper for one MSX slot. It supports the nomapper, Konami, Konami SCC, ASCII8, ASCII16 and linear modes in a single block. It translates CPU slot addresses into external memory addresses through runtime bank registers. It also runs a wait-state read handshake to the memory backend (BRAM or SDRAM front end), with a timeout.

Parameters:
ADDR_W, 25, width of mem_addr and rom_size.
BANK_W, 8, bank register width (1..8); CPU data bits above BANK_W are ignored.
TIMEOUT, 255, maximum clk_en ticks waited for mem_ack before the read is abandoned (1..65535).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_en  in  1  timeout tick enable
mode  in  3  1 nomapper, 3 Konami, 4 Konami SCC, 5 ASCII8, 6 ASCII16, 7 linear; 0 and 2 treated as 1
rom_size  in  ADDR_W  ROM image size in bytes, power of two
addr  in  16  CPU address
d_from_cpu  in  8  CPU write data
wr  in  1  CPU write strobe
rd  in  1  CPU read strobe
cs  in  1  slot select, active high
d_to_cpu  out  8  read data
cpu_wait  out  1  CPU wait request
mem_addr  out  ADDR_W  translated address
mem_rd_req  out  1  backend read request
mem_ack  in  1  backend data valid, one-cycle pulse
mem_data  in  8  backend read data
bank_dbg  out  4*BANK_W  bank registers {b3,b2,b1,b0}

Behaviour:
- Reset values: d_to_cpu=FF, cpu_wait=0, mem_rd_req=0, FSM=IDLE, timeout counter=0, bank registers at the mode defaults.
- Mode defaults:
  - Konami / SCC: b0..b3 = 0,1,2,3.
  - ASCII8 / ASCII16: all 0.
- Mode change: bank registers reload defaults on the cycle after mode differs from its registered copy.
- Bank writes:
  - Commit once per write, on the rising edge of (wr & cs), registered.
  - Held strobes do not rewrite.
- Write decode:
  - Konami: 6000-7FFF→b1, 8000-9FFF→b2, A000-BFFF→b3; b0 is fixed at 0.
  - SCC: 5000-57FF→b0, 7000-77FF→b1, 9000-97FF→b2, B000-B7FF→b3.
  - ASCII8: 6000-67FF→b0, 6800-6FFF→b1, 7000-77FF→b2, 7800-7FFF→b3.
  - ASCII16: 6000-67FF→b0, 7000-77FF→b1.
- Translation (combinational, registered at request issue), with mask = rom_size-1:
  - 8K modes: page p = addr[14:13]^2'b10 for window 4000-BFFF; mem_addr = ({bank_p,addr[12:0]}) & mask.
  - ASCII16: page = addr[15]; mem_addr = ({bank,addr[13:0]}) & mask.
  - nomapper: (addr-4000h) & mask, window 4000-BFFF.
  - linear: addr & mask, window 0000-FFFF.
  - Bank numbers beyond rom_size wrap via the mask.
- Read FSM:
  - IDLE: on a rising edge of (rd & cs) inside the window, latch mem_addr, set mem_rd_req=1 and cpu_wait=1, go to REQ.
  - IDLE: a rise outside the window leaves d_to_cpu=FF, makes no request, and goes to HOLD.
  - REQ: on mem_ack, d_to_cpu←mem_data, mem_rd_req=0, cpu_wait=0, go to HOLD.
  - REQ: if TIMEOUT clk_en ticks pass without ack, d_to_cpu←FF, drop req and wait, go to HOLD.
  - HOLD: when rd=0 or cs=0, go to IDLE.
- mem_ack is ignored outside REQ.
- A bank write during REQ does not alter the latched mem_addr.
- rd and wr both rising in the same cycle: the write commits and no read is started.
- reset_n low mid-REQ: req and wait drop immediately (asynchronous).

Optional Feature:
CART_BANK_READBACK_EN
- Defined: in ASCII8/ASCII16 modes, reads of 7FF8-7FFB return {0,b0..b3} zero-extended. The FSM goes directly to HOLD with no backend request and no wait.
- Undefined: these addresses behave as ordinary ROM reads.

Decomposition:
- Package cart_mapper_pkg holds:
  - the mode constants (MODE_NOMAP=1, KONAMI=3, SCC=4, ASCII8=5, ASCII16=6, LINEAR=7);
  - the FSM state typedef;
  - the window bounds.
- Sub-module cart_bank_regs holds the bank registers, write decode, edge detect and mode-change reload, and outputs the bank vector.
- The translation and FSM stay in the top module.

Test Plan:
1. Konami, rom_size=20000h: write 05 to 8000, then read 8123 → mem_addr=0A123; cpu_wait held until mem_ack; d_to_cpu=mem_data.
2. ASCII16, rom_size=40000h: write 0F to 7000, then read 9000 → mem_addr=3D000; write 12 to 6000 → b0=12 and a read of 4000 gives mem_addr=48000&3FFFF=08000.
3. Timeout with TIMEOUT=4 and no mem_ack: read 4000 → after 4 clk_en ticks d_to_cpu=FF, cpu_wait=0, mem_rd_req=0.
4. Mode change 3→5 with banks dirty → all banks 0 next cycle; a wr held high 10 cycles at 6000 commits exactly once.
5. Reset asserted during REQ → mem_rd_req=0, cpu_wait=0, d_to_cpu=FF, SCC defaults 0,1,2,3 after release; read C000 in ASCII8 mode → FF, no request.
6. With CART_BANK_READBACK_EN, ASCII8, b2=33: read 7FFA → d_to_cpu=33, mem_rd_req never asserted.
